// File: rtl/count_checker.sv
// -----------------------------------------------------------------------------
// count_checker
// Watches a free-running 8-bit counter stream and decides whether it is
// incrementing cleanly. After LOCK_LEN consecutive in-sequence samples the
// checker declares lock. While locked, a wrong sample is either a source
// restart (value 8'h00) or a sequence error. Errors are tallied with
// saturation, and clean in-lock 8'hFF->8'h00 wraps are counted modulo 2^16.
//
// State table
//   state   | meaning
//   SEARCH  | no reference yet; the next valid sample seeds the prediction
//   ACQUIRE | building a run of in-sequence samples towards LOCK_LEN
//   LOCKED  | run reached LOCK_LEN; breaks are reported as err or restart
//
// Ports
//   clk         in   clock, all state changes on the rising edge
//   rst         in   asynchronous active-low reset
//   count_in    in   [7:0] observed counter value
//   count_valid in   count_in is sampled only when high
//   clear       in   synchronous clear of state and statistics (wins over valid)
//   locked      out  high while in LOCKED
//   err         out  one-cycle pulse on an in-lock sequence break
//   restart     out  one-cycle pulse when an in-lock break reads 8'h00
//   expected    out  [7:0] next predicted value
//   err_count   out  [7:0] saturating error tally
//   wrap_count  out  [15:0] in-lock wrap tally, modulo 2^16
// -----------------------------------------------------------------------------
module count_checker #(
   parameter int LOCK_LEN = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  count_in,
   input  logic        count_valid,
   input  logic        clear,
   output logic        locked,
   output logic        err,
   output logic        restart,
   output logic [7:0]  expected,
   output logic [7:0]  err_count,
   output logic [15:0] wrap_count
);

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_LEN_W = 4'(LOCK_LEN);

   state_t      state_q,      state_d;
   logic [3:0]  run_len_q,    run_len_d;
   logic [7:0]  expected_q,   expected_d;
   logic [7:0]  err_count_q,  err_count_d;
   logic [15:0] wrap_count_q, wrap_count_d;
   logic        err_q,        err_d;
   logic        restart_q,    restart_d;

   logic        match;
   logic [7:0]  count_inc;
   logic [3:0]  run_len_inc;

   assign match       = (count_in == expected_q);
   assign count_inc   = count_in + 8'd1;
   assign run_len_inc = run_len_q + 4'd1;

   // -------------------------------------------------------------------------
   // Next-state and statistics logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      run_len_d    = run_len_q;
      expected_d   = expected_q;
      err_count_d  = err_count_q;
      wrap_count_d = wrap_count_q;
      err_d        = 1'b0;
      restart_d    = 1'b0;

      if (clear) begin
         state_d      = ST_SEARCH;
         run_len_d    = 4'd0;
         expected_d   = 8'h00;
         err_count_d  = 8'h00;
         wrap_count_d = 16'h0000;
      end else if (count_valid) begin
         unique case (state_q)
            ST_SEARCH: begin
               expected_d = count_inc;
               run_len_d  = 4'd1;
               state_d    = ST_ACQUIRE;
            end

            ST_ACQUIRE: begin
               if (match) begin
                  expected_d = count_inc;
                  run_len_d  = run_len_inc;
                  if (run_len_inc == LOCK_LEN_W) begin
                     state_d = ST_LOCKED;
                  end
               end else begin
                  // Out-of-sequence while acquiring just restarts the run.
                  expected_d = count_inc;
                  run_len_d  = 4'd1;
               end
            end

            ST_LOCKED: begin
               if (match) begin
                  expected_d = count_inc;
                  // A matching 8'h00 can only follow 8'hFF, so it is a wrap.
                  if (count_in == 8'h00) begin
                     wrap_count_d = wrap_count_q + 16'd1;
                  end
               end else if (count_in == 8'h00) begin
                  // Source came out of reset: not counted as an error.
                  restart_d  = 1'b1;
                  expected_d = 8'h01;
                  run_len_d  = 4'd1;
                  state_d    = ST_ACQUIRE;
               end else begin
                  err_d      = 1'b1;
                  if (err_count_q != 8'hFF) begin
                     err_count_d = err_count_q + 8'd1;
                  end
                  expected_d = count_inc;
                  run_len_d  = 4'd1;
                  state_d    = ST_ACQUIRE;
               end
            end

            default: begin
               state_d    = ST_SEARCH;
               run_len_d  = 4'd0;
               expected_d = 8'h00;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // State and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_SEARCH;
         run_len_q    <= 4'd0;
         expected_q   <= 8'h00;
         err_count_q  <= 8'h00;
         wrap_count_q <= 16'h0000;
         err_q        <= 1'b0;
         restart_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         run_len_q    <= run_len_d;
         expected_q   <= expected_d;
         err_count_q  <= err_count_d;
         wrap_count_q <= wrap_count_d;
         err_q        <= err_d;
         restart_q    <= restart_d;
      end
   end

   assign locked     = (state_q == ST_LOCKED);
   assign err        = err_q;
   assign restart    = restart_q;
   assign expected   = expected_q;
   assign err_count  = err_count_q;
   assign wrap_count = wrap_count_q;

endmodule

// File: tb/tb_count_checker.sv
module tb_count_checker;

   localparam int LOCK_LEN = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  count_in;
   logic        count_valid;
   logic        clear;
   logic        locked;
   logic        err;
   logic        restart;
   logic [7:0]  expected;
   logic [7:0]  err_count;
   logic [15:0] wrap_count;

   int checks = 0;
   int errors = 0;

   count_checker #(.LOCK_LEN(LOCK_LEN)) dut (
      .clk        (clk),
      .rst        (rst),
      .count_in   (count_in),
      .count_valid(count_valid),
      .clear      (clear),
      .locked     (locked),
      .err        (err),
      .restart    (restart),
      .expected   (expected),
      .err_count  (err_count),
      .wrap_count (wrap_count)
   );

   always #5 clk = ~clk;

   // Behavioural reference: mode 0 = hunting, 1 = building a run, 2 = locked.
   int m_mode, m_run, m_exp, m_errs, m_wraps, m_err, m_rst;

   task automatic m_reset();
      m_mode = 0; m_run = 0; m_exp = 0; m_errs = 0; m_wraps = 0;
      m_err = 0; m_rst = 0;
   endtask

   task automatic m_step(input int v, input int d, input int c);
      m_err = 0; m_rst = 0;
      if (c != 0) begin
         m_reset();
      end else if (v != 0) begin
         if (m_mode == 0) begin
            m_exp = (d + 1) % 256; m_run = 1; m_mode = 1;
         end else if (m_mode == 1) begin
            if (d == m_exp) begin
               m_exp = (m_exp + 1) % 256; m_run++;
               if (m_run >= LOCK_LEN) m_mode = 2;
            end else begin
               m_exp = (d + 1) % 256; m_run = 1;
            end
         end else begin
            if (d == m_exp) begin
               if (d == 0) m_wraps = (m_wraps + 1) % 65536;
               m_exp = (m_exp + 1) % 256;
            end else if (d == 0) begin
               m_rst = 1; m_exp = 1; m_run = 1; m_mode = 1;
            end else begin
               m_err = 1; m_errs = (m_errs < 255) ? m_errs + 1 : 255;
               m_exp = (d + 1) % 256; m_run = 1; m_mode = 1;
            end
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".locked"},     int'(locked),     (m_mode == 2) ? 1 : 0);
      chk({tag, ".err"},        int'(err),        m_err);
      chk({tag, ".restart"},    int'(restart),    m_rst);
      chk({tag, ".expected"},   int'(expected),   m_exp);
      chk({tag, ".err_count"},  int'(err_count),  m_errs);
      chk({tag, ".wrap_count"}, int'(wrap_count), m_wraps);
      if (err && restart) chk({tag, ".err_and_restart"}, 1, 0);
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic c, input string tag);
      count_valid = v; count_in = d; clear = c;
      @(posedge clk);
      m_step(int'(v), int'(d), int'(c));
      #1;
      chk_model(tag);
   endtask

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       c;
      logic       lk;
      logic       e;
      logic       r;
      logic [7:0] ex;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [7:0] bad;
      logic [7:0] seq;
      int         gap_errs;

      tbl.push_back('{1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11});
      tbl.push_back('{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12});
      tbl.push_back('{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 8'h13});
      tbl.push_back('{1'b1, 8'h13, 1'b0, 1'b1, 1'b0, 1'b0, 8'h14});
      tbl.push_back('{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      tbl.push_back('{1'b1, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFD});
      tbl.push_back('{1'b1, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE});
      tbl.push_back('{1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF});
      tbl.push_back('{1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
      tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01});
      tbl.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02});
      tbl.push_back('{1'b0, 8'h99, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02});

      rst = 1'b0; count_valid = 1'b0; count_in = 8'h00; clear = 1'b0;
      m_reset();
      #3;
      chk_model("reset");
      @(posedge clk); #2;
      rst = 1'b1;

      // Table: lock, clear-wins, wrap, gap
      foreach (tbl[i]) begin
         step(tbl[i].v, tbl[i].d, tbl[i].c, $sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d.locked_t", i),   int'(locked),   int'(tbl[i].lk));
         chk($sformatf("tbl%0d.err_t", i),      int'(err),      int'(tbl[i].e));
         chk($sformatf("tbl%0d.restart_t", i),  int'(restart),  int'(tbl[i].r));
         chk($sformatf("tbl%0d.expected_t", i), int'(expected), int'(tbl[i].ex));
      end
      chk("wrap_once", int'(wrap_count), 1);

      // Source restart while locked at 40
      step(1'b0, 8'h00, 1'b1, "rs_clr");
      for (int k = 0; k < 4; k++) step(1'b1, 8'h3D + 8'(k), 1'b0, "rs_lock");
      chk("rs_locked", int'(locked), 1);
      step(1'b1, 8'h00, 1'b0, "rs_00");
      chk("rs_pulse", int'(restart), 1);
      chk("rs_noerr", int'(err), 0);
      chk("rs_errcnt", int'(err_count), 0);
      chk("rs_acquire", int'(locked), 0);
      chk("rs_exp", int'(expected), 8'h01);
      step(1'b1, 8'h01, 1'b0, "rs_r1");
      chk("rs_pulse_once", int'(restart), 0);
      step(1'b1, 8'h02, 1'b0, "rs_r2");
      chk("rs_not_yet", int'(locked), 0);
      step(1'b1, 8'h03, 1'b0, "rs_r3");
      chk("rs_relock", int'(locked), 1);

      // Break while locked at 40
      step(1'b0, 8'h00, 1'b1, "bk_clr");
      for (int k = 0; k < 4; k++) step(1'b1, 8'h3D + 8'(k), 1'b0, "bk_lock");
      step(1'b1, 8'h77, 1'b0, "bk_77");
      chk("bk_err", int'(err), 1);
      chk("bk_errcnt", int'(err_count), 1);
      chk("bk_unlock", int'(locked), 0);
      chk("bk_exp", int'(expected), 8'h78);
      step(1'b1, 8'h78, 1'b0, "bk_r1");
      chk("bk_err_once", int'(err), 0);
      step(1'b1, 8'h79, 1'b0, "bk_r2");
      step(1'b1, 8'h7A, 1'b0, "bk_r3");
      chk("bk_relock", int'(locked), 1);

      // In-sequence stream with random valid gaps: never an error
      gap_errs = 0;
      seq = expected;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 2) != 0) begin
            step(1'b1, seq, 1'b0, "gap");
            seq = seq + 8'd1;
         end else begin
            step(1'b0, 8'($urandom), 1'b0, "gap");
         end
         if (err || restart || !locked) gap_errs++;
      end
      chk("gap_clean", gap_errs, 0);

      // Asynchronous reset mid-lock
      rst = 1'b0;
      #1;
      m_reset();
      chk_model("async_rst");
      @(posedge clk); #2;
      rst = 1'b1;
      step(1'b1, 8'hA0, 1'b0, "rl0");
      for (int k = 1; k < LOCK_LEN; k++) begin
         chk("rl_not_yet", int'(locked), 0);
         step(1'b1, 8'hA0 + 8'(k), 1'b0, "rl");
      end
      chk("rl_locked", int'(locked), 1);

      // Random mixed traffic against the reference
      for (int k = 0; k < 1500; k++) begin
         int sel;
         logic [7:0] d;
         sel = int'($urandom_range(0, 9));
         if (sel < 6)       d = 8'(m_exp);
         else if (sel == 6) d = 8'h00;
         else               d = 8'($urandom);
         step(($urandom_range(0, 4) != 0), d, ($urandom_range(0, 199) == 0), "rnd");
      end

      // 300 in-lock breaks saturate err_count
      step(1'b0, 8'h00, 1'b1, "sat_clr");
      for (int k = 0; k < LOCK_LEN; k++) step(1'b1, 8'h20 + 8'(k), 1'b0, "sat_lock");
      for (int i = 0; i < 300; i++) begin
         for (int k = 0; k < LOCK_LEN - 1; k++) step(1'b1, 8'(m_exp), 1'b0, "sat_relock");
         bad = 8'(m_exp) ^ 8'h55;
         if (bad == 8'h00) bad = 8'h33;
         step(1'b1, bad, 1'b0, "sat_break");
      end
      chk("sat_errcnt", int'(err_count), 8'hFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 The block SHALL have parameter LOCK_LEN, default 4, giving the number of consecutive in-sequence samples needed to declare lock (legal 2..15).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset; low forces the reset state immediately.
REQ-004 The block SHALL have port count_in, input, 8 bits: observed counter value from the counter source.
REQ-005 The block SHALL have port count_valid, input, 1 bit: count_in sampled only on cycles where this is high.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous clear of state and statistics.
REQ-007 The block SHALL have port locked, output, 1 bit: high while the state is LOCKED.
REQ-008 The block SHALL have port err, output, 1 bit: one-cycle pulse on an in-lock sequence break.
REQ-009 The block SHALL have port restart, output, 1 bit: one-cycle pulse when an in-lock sample reads 8'h00 out of sequence (source reset).
REQ-010 The block SHALL have port expected, output, 8 bits: next value predicted.
REQ-011 The block SHALL have port err_count, output, 8 bits: saturating error tally.
REQ-012 The block SHALL have port wrap_count, output, 16 bits: in-lock 8'hFF->8'h00 transitions, modulo 2^16.

Function
REQ-013 The block SHALL implement states SEARCH, ACQUIRE and LOCKED, plus a run-length counter run_len (4 bits).
REQ-014 The block SHALL only change state, counters or pulses on cycles with count_valid=1, apart from clear and rst; when count_valid=0, all registers SHALL hold and err/restart SHALL be 0.
REQ-015 In SEARCH, a valid sample SHALL set expected=count_in+1 (mod 256), set run_len=1 and move to ACQUIRE.
REQ-016 In ACQUIRE with count_in==expected, the block SHALL increment expected (mod 256) and run_len, and SHALL move to LOCKED on the same edge when run_len+1==LOCK_LEN.
REQ-017 In ACQUIRE with count_in!=expected, the block SHALL reseed expected=count_in+1, set run_len=1, stay in ACQUIRE, and assert no err.
REQ-018 In LOCKED with count_in==expected, the block SHALL increment expected, and SHALL increment wrap_count when count_in==8'h00.
REQ-019 In LOCKED with count_in!=expected and count_in==8'h00, the block SHALL pulse restart, assert no err, leave err_count unchanged, set expected=8'h01, set run_len=1 and move to ACQUIRE.
REQ-020 In LOCKED with count_in!=expected and count_in!=8'h00, the block SHALL pulse err, increment err_count (saturate at 8'hFF), set expected=count_in+1, set run_len=1 and move to ACQUIRE.
REQ-021 All outputs SHALL be registered, with 1-cycle latency from the sampling edge; the locked output SHALL equal (state==LOCKED).
REQ-022 Wrap arithmetic: expected SHALL be 8'hFF+1=8'h00, with a matching 8'h00 counted as a wrap, not a restart.
REQ-023 clear=1 SHALL take priority over count_valid and SHALL return the block to the reset state on the next edge.
REQ-024 err and restart SHALL never be high in the same cycle.

Reset
REQ-025 While rst=0, or after clear, the block SHALL set state=SEARCH, run_len=0, expected=8'h00, err_count=8'h00, wrap_count=16'h0000, and locked=err=restart=0.
REQ-026 Reset asserted mid-lock SHALL drop locked asynchronously, and after release reacquisition SHALL need a SEARCH sample plus LOCK_LEN-1 matches.

Verification
REQ-027 The bench SHALL check lock: rst release, valid samples 10,11,12,13 -> locked=1 the cycle after sample 13, expected=14, err=0.
REQ-028 The bench SHALL check wrap: lock on FC..FF, then 00,01 -> wrap_count=1, no err/restart, expected=02.
REQ-029 The bench SHALL check source restart: locked at 40, then sample 00 -> restart pulse, err_count=0, state ACQUIRE, and 01,02,03 relock.
REQ-030 The bench SHALL check a break: locked at 40, then sample 77 -> err pulse, err_count=1, locked=0, expected=78, and 78,79,7A relock.
REQ-031 The bench SHALL check valid gaps and saturation: toggle count_valid randomly during an in-sequence stream -> no err; force 300 in-lock breaks -> err_count=FF.
REQ-032 The bench SHALL check reset and clear: rst low mid-lock -> all outputs at reset values immediately; clear with count_valid=1 -> clear wins and the sample is ignored.
